ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the data port (port B) of the dual-port RAM between the DMA unit and the
//  parallel PRAM engine. Replaces the combinational DMA_ENB mux.
//  Each requester posts a one-cycle strobe. The strobe is buffered in a one-entry pending slot.
//  The arbiter grants one transaction at a time, using DMA priority with a starvation guard.
//  It sequences RAM address/write/read timing and returns read data with a done pulse.
// PARAMETERS
//  ADDR_W        16  RAM word address width
//  DATA_W        32  RAM data width
//  RD_LAT        1   RAM read latency in cycles, addr-sampling edge to rdata valid (1..3)
//  STARVE_LIMIT  4   consecutive DMA grants allowed while PRAM is pending (>=1)
// PORTS
//  physical_clock  in   1       system clock; all logic on posedge
//  reset           in   1       synchronous, active-high reset
//  dma_req         in   1       one-cycle strobe; qualifies dma_we/addr/wdata
//  dma_we          in   1       1=write, 0=read
//  dma_addr        in   ADDR_W  word address
//  dma_wdata       in   DATA_W  write data
//  dma_busy        out  1       pending or in flight
//  dma_done        out  1       one-cycle completion pulse
//  dma_rdata       out  DATA_W  read data, valid while dma_done=1 on a read
//  dma_overrun     out  1       one-cycle pulse: strobe dropped because dma_busy=1
//  pram_*          -    -       same six signals as dma_*, for the PRAM requester
//  ram_addr        out  ADDR_W  to RAM port B address (registered)
//  ram_we          out  1       to RAM port B write enable (registered)
//  ram_wdata       out  DATA_W  to RAM port B write data (registered)
//  ram_rdata       in   DATA_W  from RAM port B read data
// BEHAVIOUR
//  Reset
//   - All outputs are 0 after the reset edge.
//   - State=IDLE, both pending slots empty, starve_cnt=0.
//   - Reset mid-transaction aborts it: no done pulse, ram_we=0 from the next cycle.
//  Capture
//   - x_req=1 with x_busy=0 latches {we,addr,wdata} into slot x.
//   - x_busy rises on the next cycle.
//   - x_req=1 with x_busy=1 drops the strobe and pulses x_overrun on the next cycle.
//  x_busy timing
//   - x_busy=1 from the cycle after capture until the cycle before x_done.
//   - x_busy=0 in the x_done cycle, so a strobe in the done cycle is accepted.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE
//   - IDLE: if any slot is full, select the owner, copy the slot to ram_* regs, go ISSUE.
//     Otherwise hold ram_we=0.
//   - ISSUE: one cycle; ram_addr/ram_we/ram_wdata are driven and the RAM samples them.
//     Write: next state DONE. Read: load wait_cnt=RD_LAT-1, go WAIT.
//   - WAIT: wait_cnt decrements each cycle. At 0, register ram_rdata into owner rdata, go DONE.
//   - DONE: owner done=1 for one cycle, clear the owner slot, go IDLE.
//     ram_we is 0 in every state except ISSUE.
//  Latency (strobe in cycle N)
//   - Write: done at N+3.
//   - Read: done at N+3+RD_LAT.
//   - Back-to-back throughput is one transaction per 3+RD_LAT cycles (read) or 3 (write).
//  Arbitration (in IDLE)
//   - Only one slot full: that slot wins.
//   - Both full: DMA wins unless starve_cnt==STARVE_LIMIT, then PRAM wins.
//   - starve_cnt +1 on each DMA grant while PRAM is pending; saturates at STARVE_LIMIT.
//   - starve_cnt clears on a PRAM grant, or when the PRAM slot is empty at a DMA grant.
//  Other rules
//   - Strobes from both requesters in the same cycle are both captured; no loss.
//   - x_rdata holds its last value until the next read done for that requester.
//     It is not cleared on writes.
//   - Addresses pass through unmodified; no range checking. Width wrap belongs to the RAM.
// TESTING
//  T1: reset 3 cycles; DMA read addr 0x0010, RAM[0x10]=0xDEADBEEF
//      -> ram_addr=0x0010 at N+1, dma_done at N+4 (RD_LAT=1), dma_rdata=0xDEADBEEF.
//  T2: PRAM write addr 0x1234 data 0xA5A5A5A5 -> ram_we=1 exactly at N+1, pram_done at N+3.
//      Readback via DMA returns 0xA5A5A5A5.
//  T3: both strobe in the same cycle (reads 0x1, 0x2) -> DMA serviced first, PRAM next.
//      Both done pulses occur; no overrun.
//  T4: DMA re-strobes on every done while PRAM is pending (STARVE_LIMIT=4)
//      -> exactly 4 DMA grants, then the PRAM grant, then starve_cnt=0.
//  T5: dma_req while dma_busy=1 -> dma_overrun pulse next cycle; slot contents unchanged.
//      Original transaction completes with its original data.
//  T6: reset asserted during WAIT -> no done pulse, all outputs 0, ram_we=0.
//      A fresh request after reset completes normally.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Arbitrates RAM port B between the DMA and PRAM requesters. Each requester has a
// one-entry pending slot, and DMA has priority subject to a starvation guard on PRAM.
module ram_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              physical_clock,
   input  logic              reset,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_busy,
   output logic              dma_done,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_overrun,
   input  logic              pram_req,
   input  logic              pram_we,
   input  logic [ADDR_W-1:0] pram_addr,
   input  logic [DATA_W-1:0] pram_wdata,
   output logic              pram_busy,
   output logic              pram_done,
   output logic [DATA_W-1:0] pram_rdata,
   output logic              pram_overrun,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int   SC_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic OWN_DMA   = 1'b0;
   localparam logic OWN_PRAM  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state_q;
   logic              owner_q;
   logic [1:0]        wait_cnt_q;
   logic [SC_W-1:0]   starve_q;

   logic              dma_full_q,   dma_full_d;
   logic              dma_we_q,     dma_we_d;
   logic [ADDR_W-1:0] dma_addr_q,   dma_addr_d;
   logic [DATA_W-1:0] dma_wdata_q,  dma_wdata_d;
   logic              pram_full_q,  pram_full_d;
   logic              pram_we_q,    pram_we_d;
   logic [ADDR_W-1:0] pram_addr_q,  pram_addr_d;
   logic [DATA_W-1:0] pram_wdata_q, pram_wdata_d;

   logic              dma_done_q,   pram_done_q;
   logic              dma_ovr_q,    pram_ovr_q;
   logic [DATA_W-1:0] dma_rdata_q,  pram_rdata_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_we_q;
   logic [DATA_W-1:0] ram_wdata_q;

   logic              starved;
   logic              grant_dma;
   logic              grant_pram;

   assign dma_busy     = dma_full_q;
   assign pram_busy    = pram_full_q;
   assign dma_done     = dma_done_q;
   assign pram_done    = pram_done_q;
   assign dma_overrun  = dma_ovr_q;
   assign pram_overrun = pram_ovr_q;
   assign dma_rdata    = dma_rdata_q;
   assign pram_rdata   = pram_rdata_q;
   assign ram_addr     = ram_addr_q;
   assign ram_we       = ram_we_q;
   assign ram_wdata    = ram_wdata_q;

   // Slot next-state: capture on an accepted strobe, release as the owner leaves DONE.
   always_comb begin
      dma_full_d   = dma_full_q;
      dma_we_d     = dma_we_q;
      dma_addr_d   = dma_addr_q;
      dma_wdata_d  = dma_wdata_q;
      pram_full_d  = pram_full_q;
      pram_we_d    = pram_we_q;
      pram_addr_d  = pram_addr_q;
      pram_wdata_d = pram_wdata_q;
      if (dma_req && !dma_full_q) begin
         dma_full_d  = 1'b1;
         dma_we_d    = dma_we;
         dma_addr_d  = dma_addr;
         dma_wdata_d = dma_wdata;
      end
      if (pram_req && !pram_full_q) begin
         pram_full_d  = 1'b1;
         pram_we_d    = pram_we;
         pram_addr_d  = pram_addr;
         pram_wdata_d = pram_wdata;
      end
      if (state_q == S_DONE && owner_q == OWN_DMA) begin
         dma_full_d = 1'b0;
      end
      if (state_q == S_DONE && owner_q == OWN_PRAM) begin
         pram_full_d = 1'b0;
      end
   end

   // Arbitrating on the next-state slots lets a strobe arriving in IDLE issue on the next cycle.
   always_comb begin
      starved    = (starve_q == SC_W'(STARVE_LIMIT));
      grant_dma  = dma_full_d && !(pram_full_d && starved);
      grant_pram = pram_full_d && !grant_dma;
   end

   always_ff @(posedge physical_clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_DMA;
         wait_cnt_q   <= '0;
         starve_q     <= '0;
         dma_full_q   <= 1'b0;
         dma_we_q     <= 1'b0;
         dma_addr_q   <= '0;
         dma_wdata_q  <= '0;
         pram_full_q  <= 1'b0;
         pram_we_q    <= 1'b0;
         pram_addr_q  <= '0;
         pram_wdata_q <= '0;
         dma_done_q   <= 1'b0;
         pram_done_q  <= 1'b0;
         dma_ovr_q    <= 1'b0;
         pram_ovr_q   <= 1'b0;
         dma_rdata_q  <= '0;
         pram_rdata_q <= '0;
         ram_addr_q   <= '0;
         ram_we_q     <= 1'b0;
         ram_wdata_q  <= '0;
      end else begin
         dma_full_q   <= dma_full_d;
         dma_we_q     <= dma_we_d;
         dma_addr_q   <= dma_addr_d;
         dma_wdata_q  <= dma_wdata_d;
         pram_full_q  <= pram_full_d;
         pram_we_q    <= pram_we_d;
         pram_addr_q  <= pram_addr_d;
         pram_wdata_q <= pram_wdata_d;
         dma_done_q   <= 1'b0;
         pram_done_q  <= 1'b0;
         dma_ovr_q    <= dma_req && dma_full_q;
         pram_ovr_q   <= pram_req && pram_full_q;
         ram_we_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_dma) begin
                  owner_q     <= OWN_DMA;
                  ram_addr_q  <= dma_addr_d;
                  ram_we_q    <= dma_we_d;
                  ram_wdata_q <= dma_wdata_d;
                  if (!pram_full_d) begin
                     starve_q <= '0;
                  end else if (!starved) begin
                     starve_q <= starve_q + 1'b1;
                  end
                  state_q <= S_ISSUE;
               end else if (grant_pram) begin
                  owner_q     <= OWN_PRAM;
                  ram_addr_q  <= pram_addr_d;
                  ram_we_q    <= pram_we_d;
                  ram_wdata_q <= pram_wdata_d;
                  starve_q    <= '0;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (ram_we_q) begin
                  state_q <= S_DONE;
               end else begin
                  wait_cnt_q <= 2'(RD_LAT - 1);
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt_q == 2'd0) begin
                  if (owner_q == OWN_PRAM) begin
                     pram_rdata_q <= ram_rdata;
                  end else begin
                     dma_rdata_q <= ram_rdata;
                  end
                  state_q <= S_DONE;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
            S_DONE: begin
               if (owner_q == OWN_PRAM) begin
                  pram_done_q <= 1'b1;
               end else begin
                  dma_done_q <= 1'b1;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a behavioural single-cycle-latency RAM on port B
// and hand-computed cycle offsets relative to the strobe cycle.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        dma_req, dma_we, pram_req, pram_we;
   logic [15:0] dma_addr, pram_addr;
   logic [31:0] dma_wdata, pram_wdata;
   logic        dma_busy, dma_done, dma_overrun;
   logic        pram_busy, pram_done, pram_overrun;
   logic [31:0] dma_rdata, pram_rdata;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [31:0] ram_wdata, ram_rdata;

   logic        bd_we;
   logic [15:0] bd_addr;
   logic [31:0] bd_data;
   logic [31:0] mem [0:65535];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .STARVE_LIMIT(4)) dut (
      .physical_clock(clk),
      .reset(rst),
      .dma_req(dma_req),
      .dma_we(dma_we),
      .dma_addr(dma_addr),
      .dma_wdata(dma_wdata),
      .dma_busy(dma_busy),
      .dma_done(dma_done),
      .dma_rdata(dma_rdata),
      .dma_overrun(dma_overrun),
      .pram_req(pram_req),
      .pram_we(pram_we),
      .pram_addr(pram_addr),
      .pram_wdata(pram_wdata),
      .pram_busy(pram_busy),
      .pram_done(pram_done),
      .pram_rdata(pram_rdata),
      .pram_overrun(pram_overrun),
      .ram_addr(ram_addr),
      .ram_we(ram_we),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // Port B model: address sampled on the edge, read data visible the following cycle.
   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      dma_req  = 1'b0;
      pram_req = 1'b0;
   endtask

   task automatic poke(input logic [15:0] a, input logic [31:0] d);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   task automatic strobe(input bit to_pram, input bit we, input logic [15:0] a, input logic [31:0] d);
      if (to_pram) begin
         pram_req = 1'b1; pram_we = we; pram_addr = a; pram_wdata = d;
      end else begin
         dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
      end
   endtask

   task automatic wait_done(input bit to_pram, output int lat, output logic [31:0] rd);
      int i;
      lat = -1;
      rd  = '0;
      i   = 0;
      while (lat < 0 && i < 20) begin
         cyc();
         i++;
         if (to_pram ? pram_done : dma_done) begin
            lat = i;
            rd  = to_pram ? pram_rdata : dma_rdata;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, dl, pl, ovr, n, pcyc, dones;
      bit          pseen;
      logic [31:0] rd, drd, prd;
      logic [31:0] seq;

      rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      pram_req = 1'b0; pram_we = 1'b0; pram_addr = '0; pram_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_dma_busy", dma_busy, 0);
      chk("rst_pram_busy", pram_busy, 0);
      chk("rst_dma_done", dma_done, 0);
      chk("rst_dma_rdata", dma_rdata, 0);
      rst = 1'b0;

      poke(16'h0010, 32'hDEADBEEF);
      poke(16'h0001, 32'h11111111);
      poke(16'h0002, 32'h22222222);
      poke(16'h0030, 32'h30303030);
      poke(16'h0040, 32'h40404040);

      // T1: DMA read
      strobe(0, 0, 16'h0010, 32'h0);
      cyc();
      chk("t1_addr_n1", ram_addr, 16'h0010);
      chk("t1_we_n1", ram_we, 0);
      chk("t1_busy_n1", dma_busy, 1);
      cyc();
      chk("t1_done_n2", dma_done, 0);
      cyc();
      chk("t1_done_n3", dma_done, 0);
      chk("t1_busy_n3", dma_busy, 1);
      cyc();
      chk("t1_done_n4", dma_done, 1);
      chk("t1_rdata", dma_rdata, 32'hDEADBEEF);
      chk("t1_busy_n4", dma_busy, 0);
      cyc();
      chk("t1_done_n5", dma_done, 0);

      // T2: PRAM write then DMA readback
      strobe(1, 1, 16'h1234, 32'hA5A5A5A5);
      cyc();
      chk("t2_we_n1", ram_we, 1);
      chk("t2_addr_n1", ram_addr, 16'h1234);
      chk("t2_wdata_n1", ram_wdata, 32'hA5A5A5A5);
      cyc();
      chk("t2_we_n2", ram_we, 0);
      chk("t2_done_n2", pram_done, 0);
      cyc();
      chk("t2_done_n3", pram_done, 1);
      chk("t2_busy_n3", pram_busy, 0);
      strobe(0, 0, 16'h1234, 32'h0);
      wait_done(0, lat, rd);
      chk("t2_rb_lat", lat, 4);
      chk("t2_rb_data", rd, 32'hA5A5A5A5);

      // T3: simultaneous reads, DMA first
      strobe(0, 0, 16'h0001, 32'h0);
      strobe(1, 0, 16'h0002, 32'h0);
      dl = -1; pl = -1; ovr = 0; drd = '0; prd = '0;
      for (int i = 1; i <= 14; i++) begin
         cyc();
         if (dma_done) begin dl = i; drd = dma_rdata; end
         if (pram_done) begin pl = i; prd = pram_rdata; end
         if (dma_overrun || pram_overrun) ovr++;
      end
      chk("t3_dma_cycle", dl, 4);
      chk("t3_pram_cycle", pl, 8);
      chk("t3_dma_rdata", drd, 32'h11111111);
      chk("t3_pram_rdata", prd, 32'h22222222);
      chk("t3_overruns", ovr, 0);

      // T4: DMA re-strobes on every done while PRAM waits
      strobe(0, 1, 16'h0100, 32'h00000100);
      strobe(1, 1, 16'h0200, 32'h00000200);
      seq = '0; n = 0; pseen = 1'b0; pcyc = -1;
      for (int i = 1; i <= 80 && n < 6; i++) begin
         cyc();
         if (dma_done) begin
            seq = (seq << 2) | 32'd1;
            n++;
            if (!pseen) strobe(0, 1, 16'h0100 + 16'(n), 32'(n));
         end
         if (pram_done) begin
            seq = (seq << 2) | 32'd2;
            n++;
            pseen = 1'b1;
            pcyc = i;
         end
      end
      chk("t4_grant_order", seq, 32'h559);
      chk("t4_pram_cycle", pcyc, 15);

      // T5: overrun leaves the pending slot untouched
      strobe(0, 0, 16'h0030, 32'h0);
      cyc();
      chk("t5_busy_n1", dma_busy, 1);
      chk("t5_ovr_n1", dma_overrun, 0);
      strobe(0, 1, 16'h0040, 32'hBAD0BAD0);
      cyc();
      chk("t5_ovr_n2", dma_overrun, 1);
      cyc();
      chk("t5_ovr_n3", dma_overrun, 0);
      chk("t5_done_n3", dma_done, 0);
      cyc();
      chk("t5_done_n4", dma_done, 1);
      chk("t5_rdata", dma_rdata, 32'h30303030);
      strobe(1, 0, 16'h0040, 32'h0);
      wait_done(1, lat, rd);
      chk("t5_no_write_lat", lat, 4);
      chk("t5_no_write_data", rd, 32'h40404040);

      // T6: reset during WAIT aborts the read
      strobe(0, 0, 16'h0010, 32'h0);
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      chk("t6_done", dma_done, 0);
      chk("t6_busy", dma_busy, 0);
      chk("t6_ram_we", ram_we, 0);
      chk("t6_ram_addr", ram_addr, 0);
      chk("t6_dma_rdata", dma_rdata, 0);
      chk("t6_pram_rdata", pram_rdata, 0);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (dma_done || pram_done) dones++;
      end
      chk("t6_no_done", dones, 0);
      strobe(0, 0, 16'h0002, 32'h0);
      wait_done(0, lat, rd);
      chk("t6_fresh_lat", lat, 4);
      chk("t6_fresh_data", rd, 32'h22222222);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
